// File: rtl/seq_idiv.sv
// Sequential signed integer divider (restoring, truncate-toward-zero), n-bit operands.
// Define SEQ_IDIV_DBZ_EN to add the dbz output and a 1-cycle divide-by-zero shortcut.
module seq_idiv #(
    parameter int n = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [n-1:0] dd,
    input  logic signed [n-1:0] dv,
    output logic                busy,
    output logic                done,
    output logic signed [n-1:0] quo,
    output logic signed [n-1:0] rem
`ifdef SEQ_IDIV_DBZ_EN
    ,
    output logic                dbz
`endif
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [n-1:0]    a_q,     a_d;
    logic [n-1:0]    b_q,     b_d;
    logic [n:0]      r_q,     r_d;
    logic            sdd_q,   sdd_d;
    logic            sdv_q,   sdv_d;
    logic            dvz_q,   dvz_d;
    logic [n-1:0]    quo_q,   quo_d;
    logic [n-1:0]    rem_q,   rem_d;
    logic            done_q,  done_d;
    logic            dbz_q,   dbz_d;

    logic [n+1:0]    shifted;
    logic [n+1:0]    diff;
    logic            ge;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            sdd_q   <= 1'b0;
            sdv_q   <= 1'b0;
            dvz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            sdd_q   <= sdd_d;
            sdv_q   <= sdv_d;
            dvz_q   <= dvz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    always_comb begin
        shifted = {r_q, a_q[n-1]};
        ge      = (shifted >= (n+2)'(b_q));
        diff    = shifted - (n+2)'(b_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        sdd_d   = sdd_q;
        sdv_d   = sdv_q;
        dvz_d   = dvz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        if (start && (state_q == IDLE || state_q == DONE)) begin
            sdd_d   = dd[n-1];
            sdv_d   = dv[n-1];
            a_d     = dd[n-1] ? $unsigned(-dd) : $unsigned(dd);
            b_d     = dv[n-1] ? $unsigned(-dv) : $unsigned(dv);
            r_d     = '0;
            cnt_d   = '0;
            dvz_d   = (dv == '0);
            state_d = CALC;
`ifdef SEQ_IDIV_DBZ_EN
            if (dv == '0) begin
                quo_d   = '1;
                rem_d   = $unsigned(dd);
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end
`endif
        end else begin
            case (state_q)
                CALC: begin
                    r_d   = (n+1)'(ge ? diff : shifted);
                    a_d   = {a_q[n-2:0], ge};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(n - 1)) state_d = FIX;
                end
                FIX: begin
                    // Divide by zero keeps the raw all-ones quotient regardless of signs.
                    quo_d   = ((sdd_q ^ sdv_q) && !dvz_q) ? -a_q : a_q;
                    rem_d   = sdd_q ? -r_q[n-1:0] : r_q[n-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = done_q;
    assign quo  = quo_q;
    assign rem  = rem_q;
`ifdef SEQ_IDIV_DBZ_EN
    assign dbz  = dbz_q;
`endif

endmodule
